// File: rtl/axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_write_arbiter
//   Two-master to one-slave AXI4 write-channel arbiter.
//   - AW: round-robin between master 0 and 1. The winner is presented with zero
//     cycle latency in IDLE. Once the shared AW valid has been shown without
//     ready, the grant is frozen (AW_HOLD) until the handshake completes.
//   - W : after an AW handshake the W channel of that master is connected to
//     the shared W channel until the beat carrying last completes.
//   - B : routed without state using bit 3 of the returned id (the master index
//     that was prepended to the AW id).
//   - At most four writes may be outstanding (AW accepted, B not yet returned).
//
// Handshake rule used on every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1. A valid, once raised, is expected to
// stay high with a stable payload until that transfer.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   auto_in_<i>_aw_* / _w_* / _b_*   slave-side ports for master i (0, 1)
//   auto_out_aw_* / _w_* / _b_*  master-side port toward the shared slave
//   beat_err                     sticky W-burst length error (only when the
//                                macro AXI4_WARB_BEATCHK_EN is defined)
//   dbg_state                    current FSM state (0 IDLE, 1 AW_HOLD, 2 W_DATA)
//   dbg_outstanding              current outstanding-write count
// -----------------------------------------------------------------------------
module axi4_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  // master 0
  input  logic        auto_in_0_aw_valid,
  output logic        auto_in_0_aw_ready,
  input  logic [2:0]  auto_in_0_aw_bits_id,
  input  logic [31:0] auto_in_0_aw_bits_addr,
  input  logic [7:0]  auto_in_0_aw_bits_len,
  input  logic [2:0]  auto_in_0_aw_bits_size,
  input  logic [1:0]  auto_in_0_aw_bits_burst,
  input  logic        auto_in_0_w_valid,
  output logic        auto_in_0_w_ready,
  input  logic [63:0] auto_in_0_w_bits_data,
  input  logic [7:0]  auto_in_0_w_bits_strb,
  input  logic        auto_in_0_w_bits_last,
  input  logic        auto_in_0_b_ready,
  output logic        auto_in_0_b_valid,
  output logic [2:0]  auto_in_0_b_bits_id,
  output logic [1:0]  auto_in_0_b_bits_resp,
  // master 1
  input  logic        auto_in_1_aw_valid,
  output logic        auto_in_1_aw_ready,
  input  logic [2:0]  auto_in_1_aw_bits_id,
  input  logic [31:0] auto_in_1_aw_bits_addr,
  input  logic [7:0]  auto_in_1_aw_bits_len,
  input  logic [2:0]  auto_in_1_aw_bits_size,
  input  logic [1:0]  auto_in_1_aw_bits_burst,
  input  logic        auto_in_1_w_valid,
  output logic        auto_in_1_w_ready,
  input  logic [63:0] auto_in_1_w_bits_data,
  input  logic [7:0]  auto_in_1_w_bits_strb,
  input  logic        auto_in_1_w_bits_last,
  input  logic        auto_in_1_b_ready,
  output logic        auto_in_1_b_valid,
  output logic [2:0]  auto_in_1_b_bits_id,
  output logic [1:0]  auto_in_1_b_bits_resp,
  // shared slave side
  output logic        auto_out_aw_valid,
  input  logic        auto_out_aw_ready,
  output logic [3:0]  auto_out_aw_bits_id,
  output logic [31:0] auto_out_aw_bits_addr,
  output logic [7:0]  auto_out_aw_bits_len,
  output logic [2:0]  auto_out_aw_bits_size,
  output logic [1:0]  auto_out_aw_bits_burst,
  output logic        auto_out_w_valid,
  input  logic        auto_out_w_ready,
  output logic [63:0] auto_out_w_bits_data,
  output logic [7:0]  auto_out_w_bits_strb,
  output logic        auto_out_w_bits_last,
  input  logic        auto_out_b_valid,
  output logic        auto_out_b_ready,
  input  logic [3:0]  auto_out_b_bits_id,
  input  logic [1:0]  auto_out_b_bits_resp,
`ifdef AXI4_WARB_BEATCHK_EN
  output logic        beat_err,
`endif
  output logic [1:0]  dbg_state,
  output logic [2:0]  dbg_outstanding
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] AW_HOLD = 2'd1;
  localparam logic [1:0] W_DATA  = 2'd2;

  localparam logic [2:0] MAX_OUTSTANDING = 3'd4;

  logic [1:0] state;
  logic       grant;
  logic       rr_ptr;
  logic       wsel;
  logic [2:0] outstanding;

  logic [1:0] in_aw_valid;
  logic       winner;
  logic       aw_sel;
  logic       aw_present;
  logic       aw_hs;
  logic       w_active;
  logic       w_hs;
  logic       b_sel;
  logic       b_hs;

  assign in_aw_valid = {auto_in_1_aw_valid, auto_in_0_aw_valid};

  // Round-robin: the pointer master wins if it asks, otherwise the other one.
  always_comb begin
    winner = ~rr_ptr;
    if (in_aw_valid[rr_ptr]) winner = rr_ptr;
  end

  // In AW_HOLD the frozen grant drives the mux so the payload cannot switch
  // while the shared valid is up.
  assign aw_sel = (state == AW_HOLD) ? grant : winner;

  always_comb begin
    aw_present = 1'b0;
    case (state)
      IDLE:    aw_present = (|in_aw_valid) && (outstanding != MAX_OUTSTANDING);
      AW_HOLD: aw_present = in_aw_valid[grant];
      default: aw_present = 1'b0;
    endcase
  end

  assign aw_hs = aw_present && auto_out_aw_ready;

  assign auto_out_aw_valid      = aw_present;
  assign auto_out_aw_bits_id    = {aw_sel, aw_sel ? auto_in_1_aw_bits_id : auto_in_0_aw_bits_id};
  assign auto_out_aw_bits_addr  = aw_sel ? auto_in_1_aw_bits_addr  : auto_in_0_aw_bits_addr;
  assign auto_out_aw_bits_len   = aw_sel ? auto_in_1_aw_bits_len   : auto_in_0_aw_bits_len;
  assign auto_out_aw_bits_size  = aw_sel ? auto_in_1_aw_bits_size  : auto_in_0_aw_bits_size;
  assign auto_out_aw_bits_burst = aw_sel ? auto_in_1_aw_bits_burst : auto_in_0_aw_bits_burst;

  assign auto_in_0_aw_ready = aw_present && !aw_sel && auto_out_aw_ready;
  assign auto_in_1_aw_ready = aw_present &&  aw_sel && auto_out_aw_ready;

  // W channel is only connected while a burst is in flight.
  assign w_active = (state == W_DATA);

  assign auto_out_w_valid     = w_active && (wsel ? auto_in_1_w_valid : auto_in_0_w_valid);
  assign auto_out_w_bits_data = wsel ? auto_in_1_w_bits_data : auto_in_0_w_bits_data;
  assign auto_out_w_bits_strb = wsel ? auto_in_1_w_bits_strb : auto_in_0_w_bits_strb;
  assign auto_out_w_bits_last = wsel ? auto_in_1_w_bits_last : auto_in_0_w_bits_last;

  assign auto_in_0_w_ready = w_active && !wsel && auto_out_w_ready;
  assign auto_in_1_w_ready = w_active &&  wsel && auto_out_w_ready;

  assign w_hs = auto_out_w_valid && auto_out_w_ready;

  // B responses carry the master index in id bit 3; no state involved.
  assign b_sel = auto_out_b_bits_id[3];

  assign auto_in_0_b_valid     = auto_out_b_valid && !b_sel;
  assign auto_in_1_b_valid     = auto_out_b_valid &&  b_sel;
  assign auto_in_0_b_bits_id   = auto_out_b_bits_id[2:0];
  assign auto_in_1_b_bits_id   = auto_out_b_bits_id[2:0];
  assign auto_in_0_b_bits_resp = auto_out_b_bits_resp;
  assign auto_in_1_b_bits_resp = auto_out_b_bits_resp;
  assign auto_out_b_ready      = b_sel ? auto_in_1_b_ready : auto_in_0_b_ready;

  assign b_hs = auto_out_b_valid && auto_out_b_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= 1'b0;
      rr_ptr <= 1'b0;
      wsel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_present) begin
            grant <= winner;
            if (auto_out_aw_ready) begin
              state  <= W_DATA;
              wsel   <= winner;
              rr_ptr <= ~winner;
            end else begin
              state <= AW_HOLD;
            end
          end
        end
        AW_HOLD: begin
          if (aw_hs) begin
            state  <= W_DATA;
            wsel   <= grant;
            rr_ptr <= ~grant;
          end
        end
        W_DATA: begin
          if (w_hs && auto_out_w_bits_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The limit check in IDLE uses the registered count, so a B returned while
  // full only frees a slot from the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= 3'd0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   if (outstanding != MAX_OUTSTANDING) outstanding <= outstanding + 3'd1;
        2'b01:   if (outstanding != 3'd0) outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef AXI4_WARB_BEATCHK_EN
  // beat_cnt counts completed beats of the current burst; exp_beats = len+1.
  logic [8:0] beat_cnt;
  logic [8:0] exp_beats;
  logic [8:0] beat_num;

  assign beat_num = beat_cnt + 9'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt  <= 9'd0;
      exp_beats <= 9'd1;
      beat_err  <= 1'b0;
    end else begin
      if (aw_hs) begin
        beat_cnt  <= 9'd0;
        exp_beats <= {1'b0, auto_out_aw_bits_len} + 9'd1;
      end else if (w_hs) begin
        if (beat_cnt != 9'h1ff) beat_cnt <= beat_num;
        // last must appear exactly on beat len+1
        if (auto_out_w_bits_last != (beat_num == exp_beats)) beat_err <= 1'b1;
      end
    end
  end
`endif

  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

endmodule

// File: tb/tb_axi4_write_arbiter.sv
module tb_axi4_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        auto_in_0_aw_valid, auto_in_1_aw_valid;
  logic        auto_in_0_aw_ready, auto_in_1_aw_ready;
  logic [2:0]  auto_in_0_aw_bits_id, auto_in_1_aw_bits_id;
  logic [31:0] auto_in_0_aw_bits_addr, auto_in_1_aw_bits_addr;
  logic [7:0]  auto_in_0_aw_bits_len, auto_in_1_aw_bits_len;
  logic [2:0]  auto_in_0_aw_bits_size, auto_in_1_aw_bits_size;
  logic [1:0]  auto_in_0_aw_bits_burst, auto_in_1_aw_bits_burst;
  logic        auto_in_0_w_valid, auto_in_1_w_valid;
  logic        auto_in_0_w_ready, auto_in_1_w_ready;
  logic [63:0] auto_in_0_w_bits_data, auto_in_1_w_bits_data;
  logic [7:0]  auto_in_0_w_bits_strb, auto_in_1_w_bits_strb;
  logic        auto_in_0_w_bits_last, auto_in_1_w_bits_last;
  logic        auto_in_0_b_ready, auto_in_1_b_ready;
  logic        auto_in_0_b_valid, auto_in_1_b_valid;
  logic [2:0]  auto_in_0_b_bits_id, auto_in_1_b_bits_id;
  logic [1:0]  auto_in_0_b_bits_resp, auto_in_1_b_bits_resp;
  logic        auto_out_aw_valid, auto_out_aw_ready;
  logic [3:0]  auto_out_aw_bits_id;
  logic [31:0] auto_out_aw_bits_addr;
  logic [7:0]  auto_out_aw_bits_len;
  logic [2:0]  auto_out_aw_bits_size;
  logic [1:0]  auto_out_aw_bits_burst;
  logic        auto_out_w_valid, auto_out_w_ready;
  logic [63:0] auto_out_w_bits_data;
  logic [7:0]  auto_out_w_bits_strb;
  logic        auto_out_w_bits_last;
  logic        auto_out_b_valid, auto_out_b_ready;
  logic [3:0]  auto_out_b_bits_id;
  logic [1:0]  auto_out_b_bits_resp;
`ifdef AXI4_WARB_BEATCHK_EN
  logic        beat_err;
`endif
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_outstanding;

  axi4_write_arbiter dut (
    .clock(clock), .reset(reset),
    .auto_in_0_aw_valid(auto_in_0_aw_valid), .auto_in_0_aw_ready(auto_in_0_aw_ready),
    .auto_in_0_aw_bits_id(auto_in_0_aw_bits_id), .auto_in_0_aw_bits_addr(auto_in_0_aw_bits_addr),
    .auto_in_0_aw_bits_len(auto_in_0_aw_bits_len), .auto_in_0_aw_bits_size(auto_in_0_aw_bits_size),
    .auto_in_0_aw_bits_burst(auto_in_0_aw_bits_burst),
    .auto_in_0_w_valid(auto_in_0_w_valid), .auto_in_0_w_ready(auto_in_0_w_ready),
    .auto_in_0_w_bits_data(auto_in_0_w_bits_data), .auto_in_0_w_bits_strb(auto_in_0_w_bits_strb),
    .auto_in_0_w_bits_last(auto_in_0_w_bits_last),
    .auto_in_0_b_ready(auto_in_0_b_ready), .auto_in_0_b_valid(auto_in_0_b_valid),
    .auto_in_0_b_bits_id(auto_in_0_b_bits_id), .auto_in_0_b_bits_resp(auto_in_0_b_bits_resp),
    .auto_in_1_aw_valid(auto_in_1_aw_valid), .auto_in_1_aw_ready(auto_in_1_aw_ready),
    .auto_in_1_aw_bits_id(auto_in_1_aw_bits_id), .auto_in_1_aw_bits_addr(auto_in_1_aw_bits_addr),
    .auto_in_1_aw_bits_len(auto_in_1_aw_bits_len), .auto_in_1_aw_bits_size(auto_in_1_aw_bits_size),
    .auto_in_1_aw_bits_burst(auto_in_1_aw_bits_burst),
    .auto_in_1_w_valid(auto_in_1_w_valid), .auto_in_1_w_ready(auto_in_1_w_ready),
    .auto_in_1_w_bits_data(auto_in_1_w_bits_data), .auto_in_1_w_bits_strb(auto_in_1_w_bits_strb),
    .auto_in_1_w_bits_last(auto_in_1_w_bits_last),
    .auto_in_1_b_ready(auto_in_1_b_ready), .auto_in_1_b_valid(auto_in_1_b_valid),
    .auto_in_1_b_bits_id(auto_in_1_b_bits_id), .auto_in_1_b_bits_resp(auto_in_1_b_bits_resp),
    .auto_out_aw_valid(auto_out_aw_valid), .auto_out_aw_ready(auto_out_aw_ready),
    .auto_out_aw_bits_id(auto_out_aw_bits_id), .auto_out_aw_bits_addr(auto_out_aw_bits_addr),
    .auto_out_aw_bits_len(auto_out_aw_bits_len), .auto_out_aw_bits_size(auto_out_aw_bits_size),
    .auto_out_aw_bits_burst(auto_out_aw_bits_burst),
    .auto_out_w_valid(auto_out_w_valid), .auto_out_w_ready(auto_out_w_ready),
    .auto_out_w_bits_data(auto_out_w_bits_data), .auto_out_w_bits_strb(auto_out_w_bits_strb),
    .auto_out_w_bits_last(auto_out_w_bits_last),
    .auto_out_b_valid(auto_out_b_valid), .auto_out_b_ready(auto_out_b_ready),
    .auto_out_b_bits_id(auto_out_b_bits_id), .auto_out_b_bits_resp(auto_out_b_bits_resp),
`ifdef AXI4_WARB_BEATCHK_EN
    .beat_err(beat_err),
`endif
    .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int exp_out = 0;

  // scoreboard queues: AW {id4, addr, len}, W {data, strb, last}
  logic [43:0] aw_exp_q[$];
  logic [72:0] w_exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on each shared-side handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (auto_out_aw_valid && auto_out_aw_ready) begin
        if (aw_exp_q.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw_out", {auto_out_aw_bits_id, auto_out_aw_bits_addr, auto_out_aw_bits_len},
                   aw_exp_q.pop_front());
      end
      if (auto_out_w_valid && auto_out_w_ready) begin
        if (w_exp_q.size() == 0) check("w_unexpected", 1, 0);
        else check("w_out", {auto_out_w_bits_data, auto_out_w_bits_strb, auto_out_w_bits_last},
                   w_exp_q.pop_front());
      end
    end
  end

  function automatic logic aw_rdy(input int m);
    return (m == 0) ? auto_in_0_aw_ready : auto_in_1_aw_ready;
  endfunction

  function automatic logic w_rdy(input int m);
    return (m == 0) ? auto_in_0_w_ready : auto_in_1_w_ready;
  endfunction

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic drive_aw(input int m, input logic [2:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
    if (m == 0) begin
      auto_in_0_aw_valid = 1'b1; auto_in_0_aw_bits_id = id; auto_in_0_aw_bits_addr = addr;
      auto_in_0_aw_bits_len = len; auto_in_0_aw_bits_size = 3'd3; auto_in_0_aw_bits_burst = 2'd1;
    end else begin
      auto_in_1_aw_valid = 1'b1; auto_in_1_aw_bits_id = id; auto_in_1_aw_bits_addr = addr;
      auto_in_1_aw_bits_len = len; auto_in_1_aw_bits_size = 3'd3; auto_in_1_aw_bits_burst = 2'd1;
    end
    aw_exp_q.push_back({m[0], id, addr, len});
  endtask

  task automatic drop_aw(input int m);
    if (m == 0) auto_in_0_aw_valid = 1'b0;
    else auto_in_1_aw_valid = 1'b0;
  endtask

  task automatic wait_aw(input int m);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (aw_rdy(m)) begin ok = 1; break; end
    end
    check("aw_handshake_seen", ok, 1);
    @(posedge clock); #1;
    drop_aw(m);
    exp_out++;
  endtask

  task automatic send_w(input int m, input int nbeats, input bit end_last);
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    bit          ok;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      l = end_last && (b == nbeats - 1);
      if (m == 0) begin
        auto_in_0_w_valid = 1'b1; auto_in_0_w_bits_data = d;
        auto_in_0_w_bits_strb = s; auto_in_0_w_bits_last = l;
      end else begin
        auto_in_1_w_valid = 1'b1; auto_in_1_w_bits_data = d;
        auto_in_1_w_bits_strb = s; auto_in_1_w_bits_last = l;
      end
      w_exp_q.push_back({d, s, l});
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clock);
        if (w_rdy(m)) begin ok = 1; break; end
      end
      check("w_handshake_seen", ok, 1);
      check("w_other_ready_low", w_rdy(1 - m), 0);
      check("w_state_wdata", dbg_state, 2);
      @(posedge clock); #1;
    end
    if (m == 0) begin auto_in_0_w_valid = 1'b0; auto_in_0_w_bits_last = 1'b0; end
    else begin auto_in_1_w_valid = 1'b0; auto_in_1_w_bits_last = 1'b0; end
  endtask

  task automatic burst(input int m, input logic [2:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input int nbeats);
    drive_aw(m, id, addr, len);
    wait_aw(m);
    send_w(m, nbeats, 1'b1);
  endtask

  task automatic send_b(input logic [3:0] id);
    auto_out_b_valid = 1'b1; auto_out_b_bits_id = id; auto_out_b_bits_resp = id[1:0];
    auto_in_0_b_ready = 1'b1; auto_in_1_b_ready = 1'b1;
    @(negedge clock);
    check("b_route_sel", {auto_in_1_b_valid, auto_in_0_b_valid}, id[3] ? 2'b10 : 2'b01);
    check("b_out_ready", auto_out_b_ready, 1);
    @(posedge clock); #1;
    auto_out_b_valid = 1'b0; auto_in_0_b_ready = 1'b0; auto_in_1_b_ready = 1'b0;
    if (exp_out > 0) exp_out--;
  endtask

  task automatic clear_inputs();
    auto_in_0_aw_valid = 0; auto_in_0_aw_bits_id = 0; auto_in_0_aw_bits_addr = 0;
    auto_in_0_aw_bits_len = 0; auto_in_0_aw_bits_size = 0; auto_in_0_aw_bits_burst = 0;
    auto_in_1_aw_valid = 0; auto_in_1_aw_bits_id = 0; auto_in_1_aw_bits_addr = 0;
    auto_in_1_aw_bits_len = 0; auto_in_1_aw_bits_size = 0; auto_in_1_aw_bits_burst = 0;
    auto_in_0_w_valid = 0; auto_in_0_w_bits_data = 0; auto_in_0_w_bits_strb = 0; auto_in_0_w_bits_last = 0;
    auto_in_1_w_valid = 0; auto_in_1_w_bits_data = 0; auto_in_1_w_bits_strb = 0; auto_in_1_w_bits_last = 0;
    auto_in_0_b_ready = 0; auto_in_1_b_ready = 0;
    auto_out_aw_ready = 1; auto_out_w_ready = 1;
    auto_out_b_valid = 0; auto_out_b_bits_id = 0; auto_out_b_bits_resp = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    aw_exp_q.delete();
    w_exp_q.delete();
    exp_out = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // vector tables
  typedef struct {
    logic v0, v1, rdy;
    logic exp_v, exp_b3, exp_r0, exp_r1;
  } arb_vec_t;

  typedef struct {
    logic       bv;
    logic [3:0] bid;
    logic [1:0] resp;
    logic       br0, br1;
    logic       exp_v0, exp_v1, exp_rdy;
  } b_vec_t;

  arb_vec_t arb_tab[5];
  b_vec_t   b_tab[5];

  initial begin
    // IDLE arbitration right after reset (round-robin pointer at master 0)
    arb_tab[0] = '{v0:0, v1:0, rdy:1, exp_v:0, exp_b3:0, exp_r0:0, exp_r1:0};
    arb_tab[1] = '{v0:1, v1:0, rdy:0, exp_v:1, exp_b3:0, exp_r0:0, exp_r1:0};
    arb_tab[2] = '{v0:0, v1:1, rdy:1, exp_v:1, exp_b3:1, exp_r0:0, exp_r1:1};
    arb_tab[3] = '{v0:1, v1:1, rdy:1, exp_v:1, exp_b3:0, exp_r0:1, exp_r1:0};
    arb_tab[4] = '{v0:1, v1:1, rdy:0, exp_v:1, exp_b3:0, exp_r0:0, exp_r1:0};
    // B routing by id bit 3
    b_tab[0] = '{bv:1, bid:4'h2, resp:2'b00, br0:1, br1:0, exp_v0:1, exp_v1:0, exp_rdy:1};
    b_tab[1] = '{bv:1, bid:4'hA, resp:2'b10, br0:1, br1:0, exp_v0:0, exp_v1:1, exp_rdy:0};
    b_tab[2] = '{bv:1, bid:4'hF, resp:2'b11, br0:0, br1:1, exp_v0:0, exp_v1:1, exp_rdy:1};
    b_tab[3] = '{bv:0, bid:4'h9, resp:2'b01, br0:1, br1:1, exp_v0:0, exp_v1:0, exp_rdy:1};
    b_tab[4] = '{bv:1, bid:4'h5, resp:2'b01, br0:0, br1:1, exp_v0:1, exp_v1:0, exp_rdy:0};

    do_reset();

    // reset state
    @(negedge clock);
    check("rst_state", dbg_state, 0);
    check("rst_outstanding", dbg_outstanding, 0);
    check("rst_aw_valid", auto_out_aw_valid, 0);
    check("rst_w_valid", auto_out_w_valid, 0);
    check("rst_w_ready", {auto_in_1_w_ready, auto_in_0_w_ready}, 0);
    check("rst_aw_ready", {auto_in_1_aw_ready, auto_in_0_aw_ready}, 0);

    // combinational arbitration, applied and removed between two rising edges
    auto_in_0_aw_bits_addr = 32'hA000_0000; auto_in_1_aw_bits_addr = 32'hB000_0001;
    auto_in_0_aw_bits_id = 3'd2; auto_in_1_aw_bits_id = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      auto_in_0_aw_valid = arb_tab[i].v0; auto_in_1_aw_valid = arb_tab[i].v1;
      auto_out_aw_ready = arb_tab[i].rdy;
      #1;
      check("arb_valid", auto_out_aw_valid, arb_tab[i].exp_v);
      check("arb_in_ready", {auto_in_1_aw_ready, auto_in_0_aw_ready},
            {arb_tab[i].exp_r1, arb_tab[i].exp_r0});
      if (arb_tab[i].exp_v) begin
        check("arb_id", auto_out_aw_bits_id,
              arb_tab[i].exp_b3 ? 4'hE : 4'h2);
        check("arb_addr", auto_out_aw_bits_addr,
              arb_tab[i].exp_b3 ? 32'hB000_0001 : 32'hA000_0000);
      end
      #1;
      auto_in_0_aw_valid = 0; auto_in_1_aw_valid = 0; auto_out_aw_ready = 1;
    end
    check("arb_state_idle", dbg_state, 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      auto_out_b_valid = b_tab[i].bv; auto_out_b_bits_id = b_tab[i].bid;
      auto_out_b_bits_resp = b_tab[i].resp;
      auto_in_0_b_ready = b_tab[i].br0; auto_in_1_b_ready = b_tab[i].br1;
      #1;
      check("b_valid", {auto_in_1_b_valid, auto_in_0_b_valid}, {b_tab[i].exp_v1, b_tab[i].exp_v0});
      check("b_ready", auto_out_b_ready, b_tab[i].exp_rdy);
      check("b_id", b_tab[i].bid[3] ? auto_in_1_b_bits_id : auto_in_0_b_bits_id, b_tab[i].bid[2:0]);
      check("b_resp", b_tab[i].bid[3] ? auto_in_1_b_bits_resp : auto_in_0_b_bits_resp, b_tab[i].resp);
      #1;
      auto_out_b_valid = 0; auto_in_0_b_ready = 0; auto_in_1_b_ready = 0;
    end
    @(posedge clock); #1;
    check("b_no_underflow", dbg_outstanding, 0);

    // both masters request together: master 0 first, then master 1
    drive_aw(0, 3'd1, 32'h0000_1000, 8'd0);
    drive_aw(1, 3'd7, 32'h0000_2000, 8'd0);
    wait_aw(0);
    send_w(0, 1, 1'b1);
    wait_aw(1);
    send_w(1, 1, 1'b1);
    @(negedge clock);
    check("both_outstanding", dbg_outstanding, 3'(exp_out));
    @(posedge clock); #1;
    send_b(4'h1);
    send_b(4'hF);
    @(negedge clock);
    check("drain_outstanding", dbg_outstanding, 3'(exp_out));
    @(posedge clock); #1;

    // master 1 held by slave for three cycles while master 0 starts asking
    auto_out_aw_ready = 0;
    drive_aw(1, 3'd5, 32'h0000_3400, 8'd0);
    @(negedge clock);
    check("hold_valid", auto_out_aw_valid, 1);
    check("hold_id_c1", auto_out_aw_bits_id, 4'hD);
    @(posedge clock); #1;
    drive_aw(0, 3'd1, 32'h0000_5000, 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("hold_id", auto_out_aw_bits_id, 4'hD);
      check("hold_addr", auto_out_aw_bits_addr, 32'h0000_3400);
      check("hold_in0_ready", auto_in_0_aw_ready, 0);
      check("hold_state", dbg_state, 1);
      @(posedge clock); #1;
    end
    auto_out_aw_ready = 1;
    @(negedge clock);
    check("hold_hs_cycle4", {auto_in_1_aw_ready, auto_in_0_aw_ready}, 2'b10);
    @(posedge clock); #1;
    drop_aw(1);
    exp_out++;
    send_w(1, 1, 1'b1);
    wait_aw(0);
    send_w(0, 1, 1'b1);
    send_b(4'hD);
    send_b(4'h1);

    // four-beat burst from master 0
    burst(0, 3'd3, 32'h0001_0000, 8'd3, 4);
    @(negedge clock);
    check("burst_idle_after_last", dbg_state, 0);
    check("burst_w_valid_off", auto_out_w_valid, 0);
    @(posedge clock); #1;
    send_b(4'h3);

    // outstanding limit
    for (int i = 0; i < 4; i++) burst(i % 2, 3'(i), 32'h0002_0000 + 32'(i * 64), 8'd0, 1);
    @(negedge clock);
    check("full_outstanding", dbg_outstanding, 4);
    @(posedge clock); #1;
    drive_aw(0, 3'd4, 32'h0003_0000, 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("full_aw_blocked", auto_out_aw_valid, 0);
      check("full_in0_ready", auto_in_0_aw_ready, 0);
      @(posedge clock); #1;
    end
    auto_out_b_valid = 1; auto_out_b_bits_id = 4'hA; auto_out_b_bits_resp = 2'b00;
    auto_in_1_b_ready = 1;
    @(negedge clock);
    check("full_b_in1", {auto_in_1_b_valid, auto_in_0_b_valid}, 2'b10);
    check("full_b_same_cycle", auto_out_aw_valid, 0);
    @(posedge clock); #1;
    auto_out_b_valid = 0; auto_in_1_b_ready = 0;
    @(negedge clock);
    check("full_unblocked", auto_out_aw_valid, 1);
    @(posedge clock); #1;
    drop_aw(0);
    send_w(0, 1, 1'b1);
    @(negedge clock);
    check("full_again", dbg_outstanding, 4);
    @(posedge clock); #1;
    exp_out = 4;
    for (int i = 0; i < 4; i++) send_b((i % 2 == 0) ? 4'h8 : 4'h0);
    @(negedge clock);
    check("full_drained", dbg_outstanding, 3'(exp_out));
    @(posedge clock); #1;

`ifdef AXI4_WARB_BEATCHK_EN
    @(negedge clock);
    check("beat_err_init", beat_err, 0);
    @(posedge clock); #1;
    burst(0, 3'd0, 32'h0004_0000, 8'd1, 1);
    @(negedge clock);
    check("beat_err_set", beat_err, 1);
    @(posedge clock); #1;
    burst(1, 3'd1, 32'h0004_1000, 8'd1, 2);
    @(negedge clock);
    check("beat_err_sticky", beat_err, 1);
    do_reset();
    @(negedge clock);
    check("beat_err_reset", beat_err, 0);
    @(posedge clock); #1;
`endif

    // reset in the middle of a burst
    drive_aw(1, 3'd2, 32'h0005_0000, 8'd3);
    wait_aw(1);
    send_w(1, 1, 1'b0);
    auto_in_1_w_valid = 1; auto_in_1_w_bits_data = 64'hDEAD; auto_in_1_w_bits_last = 0;
    reset = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check("midrst_state", dbg_state, 0);
    check("midrst_outstanding", dbg_outstanding, 0);
    check("midrst_w_valid", auto_out_w_valid, 0);
    check("midrst_w_ready", auto_in_1_w_ready, 0);
    do_reset();
    @(negedge clock);
    check("post_rst_idle", dbg_state, 0);

    check("aw_q_drained", aw_exp_q.size(), 0);
    check("w_q_drained", w_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_write_arbiter.md
AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 auto_in_<i>_aw_valid / auto_in_<i>_aw_ready  input / output  1 / 1  per-master AW handshake, i=0,1.
REQ-005 auto_in_<i>_aw_bits_{id[2:0],addr[31:0],len[7:0],size[2:0],burst[1:0]}  input  AW payload.
REQ-006 auto_in_<i>_w_valid / auto_in_<i>_w_ready  input / output  1 / 1  per-master W handshake.
REQ-007 auto_in_<i>_w_bits_{data[63:0],strb[7:0],last[0]}  input  W payload.
REQ-008 auto_in_<i>_b_ready / auto_in_<i>_b_valid  input / output  1 / 1  per-master B handshake.
REQ-009 auto_in_<i>_b_bits_{id[2:0],resp[1:0]}  output  B payload.
REQ-010 auto_out_aw_{valid,ready}, auto_out_aw_bits_{id[3:0],addr,len,size,burst}  out/in/out  shared AW.
REQ-011 auto_out_w_{valid,ready}, auto_out_w_bits_{data,strb,last}  out/in/out  shared W.
REQ-012 auto_out_b_{valid,bits_id[3:0],bits_resp[1:0]} input; auto_out_b_ready output  shared B.

Function
REQ-013 States: IDLE, AW_HOLD, W_DATA; registers: state, grant (1b), rr_ptr (1b), wsel (1b), outstanding (3b, 0..4).
REQ-014 IDLE: winner = rr_ptr master if its aw_valid, else the other; no request or outstanding==4 -> auto_out_aw_valid=0.
REQ-015 IDLE with a winner: auto_out_aw_valid=1 and payload from winner combinationally (zero-cycle latency).
REQ-016 auto_out_aw_bits_id = {master index, in id[2:0]}; addr/len/size/burst passed unchanged.
REQ-017 auto_in_<i>_aw_ready = auto_out_aw_ready only for the currently presented master; 0 otherwise.
REQ-018 IDLE, out AW valid & !ready -> AW_HOLD, grant<=winner; grant frozen until handshake (no switching while valid high).
REQ-019 AW handshake (IDLE or AW_HOLD) -> W_DATA, wsel<=granted master, rr_ptr<=~granted master, outstanding+1.
REQ-020 W_DATA: auto_out_w_* = auto_in_<wsel>_w_*; auto_in_<wsel>_w_ready = auto_out_w_ready; other master w_ready=0.
REQ-021 W beat with last=1 in W_DATA -> IDLE next cycle; no AW issued during W_DATA or AW_HOLD->W transition cycle.
REQ-022 IDLE and AW_HOLD: auto_out_w_valid=0, both auto_in_<i>_w_ready=0.
REQ-023 B routing (stateless): auto_in_<k>_b_valid = auto_out_b_valid where k = auto_out_b_bits_id[3]; other 0.
REQ-024 auto_in_<k>_b_bits_id = auto_out_b_bits_id[2:0], resp passed; auto_out_b_ready = auto_in_<k>_b_ready.
REQ-025 outstanding: -1 on out B handshake; simultaneous AW and B handshake -> unchanged; never wraps.
REQ-026 outstanding==4: AW blocked; B handshake that cycle unblocks IDLE only from next cycle.

Reset
REQ-027 reset: state=IDLE, rr_ptr=0 (master 0 first), grant=0, wsel=0, outstanding=0.
REQ-028 During/after reset all out valids and all in readies that depend on state are 0; B path remains combinational.
REQ-029 Reset mid-burst abandons the burst; no recovery beats generated.

Configuration
REQ-030 Macro AXI4_WARB_BEATCHK_EN defined: 9-bit beat counter in W_DATA, cleared at AW handshake, plus output beat_err (1b).
REQ-031 With macro: beat_err sticky-set if last arrives at beat != len+1 or beat len+1 lacks last; cleared only by reset.
REQ-032 Without macro: counter and beat_err port absent; function otherwise identical.

Verification
REQ-033 Reset then both aw_valid, out ready=1 -> master0 granted (out id=0xN with bit3=0), next burst master1 (bit3=1).
REQ-034 Master1 AW, out ready low 3 cycles while master0 raises valid -> out AW stays master1, no switch, handshake cycle 4.
REQ-035 Master0 AW len=3, 4 W beats last on 4th -> all routed, master1 w_ready=0 throughout, IDLE after last.
REQ-036 Four AW/W bursts with no B -> 5th AW held (out valid=0); one B id=0b1xxx -> in1 b_valid=1, 5th AW issues next cycle.
REQ-037 With AXI4_WARB_BEATCHK_EN: len=1, last on beat 1 -> beat_err=1 and stays 1 until reset.
REQ-038 Reset asserted mid W_DATA -> next cycle state IDLE, outstanding=0, out w_valid=0.
